// File: rtl/vlog_shift_seq.sv
// Sequential shift/arithmetic engine: accepts one command, applies the selected
// operation to an accumulator once per clock for `count` steps, then holds the result.
module vlog_shift_seq #(
  parameter int WIDTH = 9,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_SLL  = 3'd0,
    OP_SRL  = 3'd1,
    OP_SLA  = 3'd2,
    OP_SRA  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_NOT  = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    rem_q, rem_d;
  logic             accept;

  // One application of the selected operation; all results wrap modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] step(input op_t f, input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = x;
    case (f)
      OP_SLL, OP_SLA: r = x << 1;
      OP_SRL:         r = x >> 1;
      OP_SRA:         r = WIDTH'($signed(x) >>> 1);
      OP_ADD:         r = x + y;
      OP_SUB:         r = x - y;
      OP_NOT:         r = ~x;
      default:        r = x;
    endcase
    return r;
  endfunction

  // Handshake outputs decode the registered state only, so no input reaches them combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign err       = out_valid && (op_q == OP_RSVD);
  assign result    = acc_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = a;
          rem_d   = count;
          state_d = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d = step(op_q, acc_q, b_q);
        rem_d = rem_q - CW'(1);
        if (rem_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_SLL;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      if (accept) begin
        op_q <= op_t'(op);
        b_q  <= b;
      end
    end
  end

  // A stalled result must not move until the consumer takes it.
  property p_result_held;
    @(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(result) && $stable(err));
  endproperty
  a_result_held: assert property (p_result_held);

  property p_err_qualified;
    @(posedge clk) disable iff (!rst_n) err |-> out_valid;
  endproperty
  a_err_qualified: assert property (p_err_qualified);

endmodule

// File: tb/tb_vlog_shift_seq.sv
// Scoreboard bench for vlog_shift_seq: expected results are queued at command issue
// and popped when the engine presents its result.
module tb_vlog_shift_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = '0;
  logic [8:0] a = '0;
  logic [8:0] b = '0;
  logic [3:0] count = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] result;
  logic       err;
  logic       busy;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [8:0] res;
    logic       err;
    int         lat;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [8:0] a;
    logic [8:0] b;
    logic [3:0] n;
    logic [8:0] res;
    logic       err;
  } cmd_t;

  exp_t sb[$];

  vlog_shift_seq #(.WIDTH(9), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Bit-level reference: repeated single steps built from concatenations.
  function automatic logic [8:0] model(input logic [2:0] o, input logic [8:0] av,
                                       input logic [8:0] bv, input logic [3:0] n);
    logic [8:0] x;
    x = av;
    for (int i = 0; i < int'(n); i++) begin
      case (o)
        3'd0, 3'd2: x = {x[7:0], 1'b0};
        3'd1:       x = {1'b0, x[8:1]};
        3'd3:       x = {x[8], x[8:1]};
        3'd4:       x = x + bv;
        3'd5:       x = x - bv;
        3'd6:       x = ~x;
        default:    x = x;
      endcase
    end
    return x;
  endfunction

  // Drive one command for one accept edge and queue its expected outcome.
  task automatic issue(input logic [2:0] o, input logic [8:0] av, input logic [8:0] bv,
                       input logic [3:0] n, input logic [8:0] er, input logic ee);
    exp_t e;
    op = o; a = av; b = bv; count = n; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
    else passes++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.res = er; e.err = ee; e.lat = int'(n);
    sb.push_back(e);
  endtask

  // Wait (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic collect(output logic [8:0] r, output logic e, output int lat, output bit ok);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = (out_valid === 1'b1);
    r = result;
    e = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (result !== 9'h000) $display("FAIL reset_result: got %h expected 000", result); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passes++;
  endtask

  // Shifts, wrap-around arithmetic, zero count and the reserved op.
  task automatic test_ops();
    cmd_t tbl[7];
    logic [8:0] r;
    logic e;
    int lat;
    bit ok;
    exp_t x;
    // Three arithmetic right shifts of 0x100 replicate the MSB three times: 0x1E0.
    tbl[0] = '{3'd3, 9'h100, 9'h000, 4'd3, 9'h1E0, 1'b0};
    tbl[1] = '{3'd1, 9'h100, 9'h000, 4'd3, 9'h020, 1'b0};
    tbl[2] = '{3'd0, 9'h0FF, 9'h000, 4'd1, 9'h1FE, 1'b0};
    tbl[3] = '{3'd4, 9'd5,   9'd200, 4'd3, 9'd93,  1'b0};
    tbl[4] = '{3'd5, 9'd0,   9'd1,   4'd1, 9'h1FF, 1'b0};
    tbl[5] = '{3'd6, 9'h0AA, 9'h000, 4'd0, 9'h0AA, 1'b0};
    tbl[6] = '{3'd7, 9'h13C, 9'h055, 4'd2, 9'h13C, 1'b1};
    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].res, tbl[i].err);
      a = ~a; op = 3'd6; count = 4'd9;
      collect(r, e, lat, ok);
      x = sb.pop_front();
      checks++;
      if (!ok) $display("FAIL ops_timeout[%0d]: out_valid=%b after %0d cycles, expected 1", i, out_valid, lat);
      else passes++;
      checks++; if (r !== x.res) $display("FAIL ops_result[%0d]: got %h expected %h", i, r, x.res); else passes++;
      checks++; if (e !== x.err) $display("FAIL ops_err[%0d]: got %b expected %b", i, e, x.err); else passes++;
      checks++; if (lat !== x.lat) $display("FAIL ops_latency[%0d]: got %0d expected %0d", i, lat, x.lat); else passes++;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0)
        $display("FAIL ops_handoff[%0d]: out_valid=%b in_ready=%b err=%b expected 0/1/0", i, out_valid, in_ready, err);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] r;
    logic e;
    int lat;
    bit ok;
    exp_t x;
    issue(3'd0, 9'h001, 9'h000, 4'd2, 9'h004, 1'b0);
    collect(r, e, lat, ok);
    x = sb.pop_front();
    checks++; if (!ok || r !== x.res) $display("FAIL bp_result: got %h ok=%b expected %h", r, ok, x.res); else passes++;
    for (int i = 0; i < 5; i++) begin
      a = 9'($urandom); op = 3'($urandom); count = 4'($urandom); in_valid = ~in_valid;
      @(posedge clk); #1;
      checks++;
      if (result !== 9'h004 || in_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL bp_hold[%0d]: result=%h in_ready=%b out_valid=%b expected 004/0/1", i, result, in_ready, out_valid);
      else passes++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_release: out_valid=%b busy=%b expected 0/0", out_valid, busy);
    else passes++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL bp_no_extra_accept: busy=%b expected 0", busy); else passes++;
  endtask

  task automatic test_reset_mid_run();
    logic [8:0] r;
    logic e;
    int lat;
    bit ok;
    bit seen;
    exp_t x;
    issue(3'd4, 9'd1, 9'd1, 4'd10, 9'd11, 1'b0);
    sb.delete(sb.size() - 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || result !== 9'h000)
      $display("FAIL midrst_idle: in_ready=%b busy=%b out_valid=%b result=%h expected 1/0/0/000", in_ready, busy, out_valid, result);
    else passes++;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL midrst_no_output: out_valid seen=%b expected 0", seen); else passes++;
    issue(3'd4, 9'd7, 9'd3, 4'd2, 9'd13, 1'b0);
    collect(r, e, lat, ok);
    x = sb.pop_front();
    checks++;
    if (!ok || r !== x.res || lat !== x.lat)
      $display("FAIL midrst_next_cmd: result=%h lat=%0d ok=%b expected %h/%0d", r, lat, ok, x.res, x.lat);
    else passes++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Commands issued at the minimum spacing with out_ready held high.
  task automatic test_back_to_back();
    logic [8:0] r;
    logic e;
    int lat;
    bit ok;
    exp_t x;
    logic [2:0] o;
    logic [8:0] av, bv;
    logic [3:0] n;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom); av = 9'($urandom); bv = 9'($urandom); n = 4'($urandom_range(0, 6));
      issue(o, av, bv, n, model(o, av, bv, n), (o == 3'd7));
      collect(r, e, lat, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || r !== x.res || e !== x.err)
        $display("FAIL b2b_result[%0d]: op=%0d result=%h err=%b ok=%b expected %h/%b", i, o, r, e, ok, x.res, x.err);
      else passes++;
      checks++;
      if (lat !== x.lat || in_ready !== 1'b0)
        $display("FAIL b2b_timing[%0d]: lat=%0d in_ready=%b expected %0d/0", i, lat, in_ready, x.lat);
      else passes++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left expected 0", sb.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
